// File: rtl/sub_pipe_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : sub_pipe_nbit
//  Brief    : Pipelined N-bit subtractor D = A - B - Bin. The borrow chain
//             is cut into SEG-bit segments with one register stage each.
//             Operand slices are skewed on entry and result slices deskewed
//             on exit so every bit of D leaves together. Also provides the
//             unsigned borrow-out, signed overflow and zero flags, a valid
//             qualifier and a global stall (en).
//  Revision : 1.0 - initial release
// ============================================================================
module sub_pipe_nbit #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
    output logic             V,
    output logic             Z
);

    localparam int c_nstg = WIDTH / SEG;

    // A partial top segment would silently drop operand bits.
    if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_width
        $error("sub_pipe_nbit: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
    end

    // Borrow registered by each stage, consumed by the next stage.
    logic r_bor [c_nstg];
    // Valid bit travelling alongside each stage.
    logic r_vld [c_nstg];
    // Signed-overflow flag, produced by the top segment.
    logic r_v;

    // Valid shift register: advances only when en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_nstg; i++) r_vld[i] <= 1'b0;
        end else if (en) begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < c_nstg; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    for (genvar j = 0; j < c_nstg; j++) begin : g_seg
        logic [SEG-1:0] w_a_s;
        logic [SEG-1:0] w_b_s;
        logic           w_bor_in;
        logic [SEG:0]   w_diff;
        logic [SEG-1:0] r_res;
        logic [SEG-1:0] w_res_out;

        if (j == 0) begin : g_noskew
            assign w_a_s    = A[SEG-1:0];
            assign w_b_s    = B[SEG-1:0];
            assign w_bor_in = Bin;
        end else begin : g_skew
            // Segment j must wait j stages for the borrow from below.
            logic [SEG-1:0] r_a_dly [j];
            logic [SEG-1:0] r_b_dly [j];

            // Operand skew line for this segment.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < j; i++) begin
                        r_a_dly[i] <= '0;
                        r_b_dly[i] <= '0;
                    end
                end else if (en) begin
                    r_a_dly[0] <= A[j*SEG +: SEG];
                    r_b_dly[0] <= B[j*SEG +: SEG];
                    for (int i = 1; i < j; i++) begin
                        r_a_dly[i] <= r_a_dly[i-1];
                        r_b_dly[i] <= r_b_dly[i-1];
                    end
                end
            end

            assign w_a_s    = r_a_dly[j-1];
            assign w_b_s    = r_b_dly[j-1];
            assign w_bor_in = r_bor[j-1];
        end

        // Top bit of the (SEG+1)-bit difference is set iff it went negative.
        assign w_diff = {1'b0, w_a_s} - {1'b0, w_b_s} - {{SEG{1'b0}}, w_bor_in};

        // Segment result and borrow register.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_res    <= '0;
                r_bor[j] <= 1'b0;
            end else if (en) begin
                r_res    <= w_diff[SEG-1:0];
                r_bor[j] <= w_diff[SEG];
            end
        end

        if (j < c_nstg - 1) begin : g_deskew
            localparam int c_depth = c_nstg - 1 - j;
            logic [SEG-1:0] r_res_dly [c_depth];

            // Result deskew line so this slice lines up with the top one.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c_depth; i++) r_res_dly[i] <= '0;
                end else if (en) begin
                    r_res_dly[0] <= r_res;
                    for (int i = 1; i < c_depth; i++) r_res_dly[i] <= r_res_dly[i-1];
                end
            end

            assign w_res_out = r_res_dly[c_depth-1];
        end else begin : g_top
            assign w_res_out = r_res;

            // Overflow: operand signs differ and the result sign left A's sign.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                end else if (en) begin
                    r_v <= (w_a_s[SEG-1] != w_b_s[SEG-1]) &&
                           (w_diff[SEG-1] != w_a_s[SEG-1]);
                end
            end
        end

        assign D[j*SEG +: SEG] = w_res_out;
    end

    assign out_valid = r_vld[c_nstg-1];
    assign B_out     = r_bor[c_nstg-1];
    assign V         = r_v;
    assign Z         = (D == '0);

endmodule
`default_nettype wire
